// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared CDB entry types and lane count
`ifndef NUM_CDB_ENTRIES
`define NUM_CDB_ENTRIES 2
`endif

package cdb_arbiter_pkg;

    localparam int ROB_IDX_W       = 6;
    localparam int NUM_CDB_ENTRIES = `NUM_CDB_ENTRIES;

    // One result broadcast: tag is the ROB index the value belongs to.
    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] tag;
        logic [31:0]          value;
    } cdb_entry_t;

    typedef cdb_entry_t [NUM_CDB_ENTRIES-1:0] cdb_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - requester/broadcast bundle between producers and the CDB arbiter
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 8,
    parameter int NUM_LANES = `NUM_CDB_ENTRIES
) ();

    cdb_entry_t [NUM_REQ-1:0]   req;
    logic       [NUM_REQ-1:0]   gnt;
    cdb_entry_t [NUM_LANES-1:0] cdb_vals;
    logic       [31:0]          busy_cycles;

    modport master (output req, input gnt, input cdb_vals, input busy_cycles);
    modport slave  (input req, output gnt, output cdb_vals, output busy_cycles);

endinterface

// File: rtl/cdb_arbiter_rr_select.sv
// rtl/cdb_arbiter_rr_select.sv - stateless round-robin pick of up to NUM_LANES requesters
module cdb_arbiter_rr_select #(
    parameter int NUM_REQ   = 8,
    parameter int NUM_LANES = 2,
    parameter int PTR_W     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]                  req_vec,
    input  logic [PTR_W-1:0]                    start,
    output logic [NUM_LANES-1:0][NUM_REQ-1:0]   picks
);

    localparam logic [PTR_W:0] NREQ = (PTR_W+1)'(NUM_REQ);

    // Each lane takes the first still-unpicked requester found searching from start, wrapping.
    always_comb begin
        logic [NUM_REQ-1:0] avail;
        logic [PTR_W:0]     pos;
        logic               found;
        picks = '0;
        avail = req_vec;
        pos   = '0;
        found = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            found = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                pos = {1'b0, start} + (PTR_W+1)'(i);
                if (pos >= NREQ) begin
                    pos = pos - NREQ;
                end
                if (!found && avail[pos[PTR_W-1:0]]) begin
                    picks[l][pos[PTR_W-1:0]] = 1'b1;
                    found = 1'b1;
                end
            end
            avail = avail & ~picks[l];
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter driving registered CDB broadcast lanes
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 8,
    parameter int NUM_LANES = `NUM_CDB_ENTRIES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(NUM_REQ + 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]                 rr_ptr;
    logic [NUM_REQ-1:0]               req_vec;
    logic [NUM_LANES-1:0][NUM_REQ-1:0] picks;
    logic [NUM_REQ-1:0]               gnt;
    cdb_entry_t [NUM_LANES-1:0]       nxt_lanes;
    cdb_entry_t [NUM_LANES-1:0]       cdb_q;
    logic [CNT_W-1:0]                 req_cnt;
    logic                             any_gnt;
    logic [PTR_W-1:0]                 last_idx;
    logic [PTR_W-1:0]                 nxt_ptr;
    logic                             busy_hit;
    logic [31:0]                      busy_q;

    // Flush or reset hides every request, so no grants and no busy count that cycle.
    always_comb begin
        req_vec = '0;
        if (rst && !flush) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                req_vec[k] = bus.req[k].valid;
            end
        end
    end

    // Count live requests to detect oversubscription of the lanes.
    always_comb begin
        req_cnt = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_cnt = req_cnt + CNT_W'(req_vec[k]);
        end
    end

    cdb_arbiter_rr_select #(
        .NUM_REQ   (NUM_REQ),
        .NUM_LANES (NUM_LANES),
        .PTR_W     (PTR_W)
    ) u_rr_select (
        .req_vec (req_vec),
        .start   (rr_ptr),
        .picks   (picks)
    );

    // Turn the one-hot picks into grants, lane payloads and the index granted on the last used lane.
    always_comb begin
        gnt       = '0;
        nxt_lanes = '0;
        any_gnt   = 1'b0;
        last_idx  = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (picks[l][k]) begin
                    gnt[k]       = 1'b1;
                    nxt_lanes[l] = bus.req[k];
                    any_gnt      = 1'b1;
                    last_idx     = PTR_W'(k);
                end
            end
        end
    end

    assign nxt_ptr  = (last_idx == LAST_IDX) ? '0 : last_idx + 1'b1;
    assign busy_hit = (req_cnt > CNT_W'(NUM_LANES));

    // Broadcast register, round-robin pointer and saturating contention counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_q  <= '0;
            rr_ptr <= '0;
            busy_q <= '0;
        end else begin
            cdb_q <= nxt_lanes;
            if (flush) begin
                rr_ptr <= '0;
            end else if (any_gnt) begin
                rr_ptr <= nxt_ptr;
            end
            if (busy_hit && (busy_q != 32'hFFFF_FFFF)) begin
                busy_q <= busy_q + 32'd1;
            end
        end
    end

    assign bus.gnt         = gnt;
    assign bus.cdb_vals    = cdb_q;
    assign bus.busy_cycles = busy_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed vector bench for cdb_arbiter
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_REQ(8), .NUM_LANES(2)) bus ();

    cdb_arbiter #(.NUM_REQ(8), .NUM_LANES(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [7:0] mask;
        logic       fl;
        logic [7:0] exp_gnt;
        int         l0;
        int         l1;
        int         exp_busy;
    } vec_t;

    vec_t vecs[14];

    function automatic cdb_entry_t ent(int k);
        cdb_entry_t e;
        e.valid = 1'b1;
        e.tag   = ROB_IDX_W'(8 + (k % 4));
        e.value = 32'hC0DE_0000 + 32'(k);
        return e;
    endfunction

    function automatic cdb_entry_t exp_lane(int idx);
        cdb_entry_t e;
        e = '0;
        if (idx >= 0) e = ent(idx);
        return e;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(logic [7:0] mask);
        for (int k = 0; k < 8; k++) begin
            bus.req[k] = mask[k] ? ent(k) : '0;
        end
    endtask

    task automatic run_vec(vec_t v, int n);
        @(negedge clk);
        drive(v.mask);
        flush = v.fl;
        #1;
        chk($sformatf("v%0d_gnt", n), 64'(bus.gnt), 64'(v.exp_gnt));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_lane0", n), 64'(bus.cdb_vals[0]), 64'(exp_lane(v.l0)));
        chk($sformatf("v%0d_lane1", n), 64'(bus.cdb_vals[1]), 64'(exp_lane(v.l1)));
        chk($sformatf("v%0d_busy", n), 64'(bus.busy_cycles), 64'(v.exp_busy));
    endtask

    initial begin
        int         got;
        int         denied;
        cdb_entry_t special;

        vecs[0]  = '{8'hFF, 1'b0, 8'h03,  0,  1, 1};
        vecs[1]  = '{8'hFF, 1'b0, 8'h0C,  2,  3, 2};
        vecs[2]  = '{8'hFF, 1'b0, 8'h30,  4,  5, 3};
        vecs[3]  = '{8'hFF, 1'b0, 8'hC0,  6,  7, 4};
        vecs[4]  = '{8'hFF, 1'b0, 8'h03,  0,  1, 5};
        vecs[5]  = '{8'h07, 1'b1, 8'h00, -1, -1, 5};
        vecs[6]  = '{8'h81, 1'b0, 8'h81,  0,  7, 5};
        vecs[7]  = '{8'h20, 1'b0, 8'h20,  5, -1, 5};
        vecs[8]  = '{8'h86, 1'b0, 8'h82,  7,  1, 6};
        vecs[9]  = '{8'h04, 1'b0, 8'h04,  2, -1, 6};
        vecs[10] = '{8'h18, 1'b0, 8'h18,  3,  4, 6};
        vecs[11] = '{8'h00, 1'b0, 8'h00, -1, -1, 6};
        vecs[12] = '{8'h41, 1'b0, 8'h41,  6,  0, 6};
        vecs[13] = '{8'h11, 1'b0, 8'h11,  4,  0, 6};

        rst   = 1'b0;
        flush = 1'b0;
        drive(8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(8'h01);
        #1;
        chk("reset_gnt", 64'(bus.gnt), 64'h0);
        chk("reset_cdb", 64'(bus.cdb_vals), 64'h0);
        chk("reset_busy", 64'(bus.busy_cycles), 64'h0);
        drive(8'h00);
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i], i);
        end

        // grant then flush: the registered broadcast still shows during the flush cycle
        @(negedge clk);
        drive(8'h04);
        flush = 1'b0;
        #1;
        chk("gf_gnt", 64'(bus.gnt), 64'h04);
        @(posedge clk);
        @(negedge clk);
        drive(8'h00);
        flush = 1'b1;
        #1;
        chk("gf_lane0_kept", 64'(bus.cdb_vals[0]), 64'(ent(2)));
        chk("gf_flush_gnt", 64'(bus.gnt), 64'h0);
        @(posedge clk);
        #1;
        chk("gf_after_flush", 64'(bus.cdb_vals), 64'h0);

        // contention: requester 5 waits two cycles then wins lane 1
        got    = 0;
        denied = 0;
        for (int c = 0; c < 4 && got == 0; c++) begin
            @(negedge clk);
            flush = 1'b0;
            drive(8'hFF);
            #1;
            if (bus.gnt[5]) got = 1;
            else denied++;
            @(posedge clk);
            #1;
        end
        chk("hold_granted", 64'(got), 64'd1);
        chk("hold_denied", 64'(denied), 64'd2);
        chk("hold_lane1", 64'(bus.cdb_vals[1]), 64'(ent(5)));
        chk("hold_busy", 64'(bus.busy_cycles), 64'd9);

        // asynchronous reset between edges
        @(negedge clk);
        drive(8'h01);
        @(posedge clk);
        #1;
        chk("ar_pre_lane0", 64'(bus.cdb_vals[0]), 64'(ent(0)));
        #2;
        rst = 1'b0;
        #1;
        chk("ar_cdb", 64'(bus.cdb_vals), 64'h0);
        chk("ar_busy", 64'(bus.busy_cycles), 64'h0);
        chk("ar_gnt", 64'(bus.gnt), 64'h0);

        // first request after reset
        @(negedge clk);
        rst = 1'b1;
        drive(8'h00);
        special.valid = 1'b1;
        special.tag   = ROB_IDX_W'(5);
        special.value = 32'hDEAD_BEEF;
        bus.req[3] = special;
        #1;
        chk("s1_gnt", 64'(bus.gnt), 64'h08);
        @(posedge clk);
        #1;
        chk("s1_lane0", 64'(bus.cdb_vals[0]), 64'(special));
        chk("s1_lane1", 64'(bus.cdb_vals[1]), 64'h0);
        run_vec('{8'h11, 1'b0, 8'h11, 4, 0, 0}, 99);

        @(negedge clk);
        drive(8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
